cbd_ctrl: RTL and testbench
===========================

// Module: cbd_ctrl
// PURPOSE
//  Sequencer for the combinational cbd sampler. Collects PRF output bytes from a
//  valid/ready stream into a 192-byte buffer, drives the cbd datapath, registers
//  its 256 coefficients, and streams them out reduced mod q (3329).
//  Sits between the SHAKE256 PRF and the polynomial memory / NTT front end.
// PARAMETERS
//  IN_W   8  input bytes per beat; power of 2, 1..64
//  OUT_N  4  coefficients per output beat; power of 2, 1..256
// PORTS
//  i_clk         in   1           clock, rising edge
//  i_rst         in   1           synchronous reset, active-high
//  i_start       in   1           start pulse; sampled in IDLE only
//  i_eta         in   2           eta for this job (2 or 3), sampled with i_start
//  o_busy        out  1           high from start acceptance to done
//  o_done        out  1           one-cycle pulse after final output beat
//  i_in_valid    in   1           input beat valid
//  o_in_ready    out  1           input beat ready
//  i_in_data     in   IN_W*8      input bytes; first byte in MSBs [IN_W*8-1 -: 8]
//  o_cbd_ibytes  out  1536        byte buffer to cbd i_ibytes
//  o_cbd_eta     out  2           latched eta to cbd i_eta
//  i_cbd_coeffs  in   768         cbd o_coeffs; coeff 0 at [767:765], 3b two's compl.
//  o_out_valid   out  1           output beat valid
//  i_out_ready   in   1           output beat ready
//  o_out_data    out  OUT_N*12    coeffs mod q; first coeff of beat in MSBs
//  o_out_last    out  1           high on final output beat (beat 256/OUT_N-1)
// BEHAVIOUR
//  Reset: state IDLE; buffer, coeff register, counters, eta reg, every output = 0.
//  States: IDLE -> LOAD -> CALC -> EMIT -> IDLE.
//  IDLE: i_start with i_eta in {2,3}: latch eta, clear buffer, byte cnt=0, busy=1,
//   -> LOAD. Start with eta 0/1 ignored (stay IDLE). i_start outside IDLE ignored.
//  LOAD: o_in_ready=1. Per handshake: buf <= {buf[1535-IN_W*8:0], i_in_data};
//   cnt += IN_W. Need = 64*eta bytes (128/192). Handshake bringing cnt to need
//   -> CALC, o_in_ready drops next cycle. Result: eta=3 byte 0 at [1535:1528];
//   eta=2 byte 0 at [1023:1016] (cbd's expected alignment).
//  CALC: one cycle; coeff reg <= i_cbd_coeffs; -> EMIT, beat idx=0.
//  EMIT: o_out_valid=1; field k (0..OUT_N-1) at [(OUT_N-k)*12-1 -: 12] carries coeff
//   idx*OUT_N+k: c>=0 ? c : 3329+c (c in -3..3, 12b result; 3'b100 maps to 3325).
//   Handshake: idx++; data holds stable while valid & !ready. Handshake on last
//   beat -> IDLE; o_done=1 and o_busy=0 in the following cycle.
//  Latency: o_out_valid rises 2 cycles after the final input handshake edge.
//  o_cbd_ibytes/o_cbd_eta driven straight from buf/eta regs (stable in CALC).
//  Synchronous reset mid-job aborts to IDLE, drops valid/ready; no done pulse.
// TESTING
//  T1 eta=3, 24 beats of 0 -> 64 beats all 0, o_out_last on beat 63, one o_done.
//  T2 eta=2, 16 beats of 0x03 bytes -> every beat {2,0,2,0}; 64 beats.
//  T3 eta=2, all bytes 0x0C -> coeffs alternate 3327,0; eta=3 repeat 0x07,0x00,0x00
//   -> beats {3,0,0,0}; repeat 0x38,0x00,0x00 -> beats {3326,0,0,0}.
//  T4 random bytes, random i_in_valid/i_out_ready gaps -> matches reference model;
//   o_out_data stable while stalled; exactly 128/192 bytes consumed.
//  T5 i_start with eta=1 -> stays IDLE; i_start during LOAD -> no effect on job.
//  T6 i_rst after 10 input beats -> all outputs 0 next cycle; new eta=3 job correct.

Source files
------------

// File: rtl/cbd_ctrl.sv
// cbd_ctrl: gathers PRF bytes into the cbd byte buffer, latches the sampled
// coefficients and streams them out reduced mod q = 3329.
`default_nettype none

module cbd_ctrl #(
   parameter int IN_W  = 8,
   parameter int OUT_N = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [1:0]            i_eta,
   output logic                  o_busy,
   output logic                  o_done,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [IN_W*8-1:0]     i_in_data,
   output logic [1535:0]         o_cbd_ibytes,
   output logic [1:0]            o_cbd_eta,
   input  logic [767:0]          i_cbd_coeffs,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [OUT_N*12-1:0]   o_out_data,
   output logic                  o_out_last
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] CALC = 2'd2;
   localparam logic [1:0] EMIT = 2'd3;

   localparam int         BEATS    = 256 / OUT_N;
   localparam logic [7:0] LAST_IDX = 8'(BEATS - 1);
   localparam logic [7:0] IN_STEP  = 8'(IN_W);

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [1535:0] byte_buf;
   logic [767:0]  coeff_reg;
   logic [1:0]    eta_reg;
   logic [7:0]    byte_cnt;
   logic [7:0]    beat_idx;
   logic          done_reg;

   logic          start_ok;
   logic          in_hs;
   logic          out_hs;
   logic [7:0]    need;
   logic          load_done;
   logic          emit_done;

   // eta of 2 or 3 is exactly the case where bit 1 is set
   assign start_ok  = i_start && i_eta[1];
   assign in_hs     = (state == LOAD) && i_in_valid;
   assign out_hs    = (state == EMIT) && i_out_ready;
   assign need      = (eta_reg == 2'd3) ? 8'd192 : 8'd128;
   assign load_done = in_hs && ((byte_cnt + IN_STEP) == need);
   assign emit_done = out_hs && (beat_idx == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_ok)  next_state = LOAD;
         LOAD:    if (load_done) next_state = CALC;
         CALC:                   next_state = EMIT;
         EMIT:    if (emit_done) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         byte_buf  <= '0;
         coeff_reg <= '0;
         eta_reg   <= 2'd0;
         byte_cnt  <= 8'd0;
         beat_idx  <= 8'd0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= emit_done;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  eta_reg  <= i_eta;
                  byte_buf <= '0;
                  byte_cnt <= 8'd0;
               end
            end
            LOAD: begin
               // shifting in from the LSBs leaves byte 0 where cbd expects it
               if (in_hs) begin
                  byte_buf <= {byte_buf[1535-IN_W*8:0], i_in_data};
                  byte_cnt <= byte_cnt + IN_STEP;
               end
            end
            CALC: begin
               coeff_reg <= i_cbd_coeffs;
               beat_idx  <= 8'd0;
            end
            EMIT: begin
               if (out_hs) beat_idx <= beat_idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

   function automatic logic [11:0] to_mod_q(input logic [2:0] c);
      // negative c (two's complement 4..7) maps to 3329 + c = 3321 + raw
      return c[2] ? (12'd3321 + {9'd0, c}) : {9'd0, c};
   endfunction

   logic [2:0] coeff_arr [256];
   logic [7:0] beat_base;

   assign beat_base = 8'(beat_idx * OUT_N);

   for (genvar i = 0; i < 256; i++) begin : g_unpack
      assign coeff_arr[i] = coeff_reg[767-3*i -: 3];
   end

   for (genvar k = 0; k < OUT_N; k++) begin : g_field
      assign o_out_data[(OUT_N-k)*12-1 -: 12] = to_mod_q(coeff_arr[beat_base + 8'(k)]);
   end

   always_comb begin
      o_busy      = (state != IDLE);
      o_in_ready  = (state == LOAD);
      o_out_valid = (state == EMIT);
      o_out_last  = (state == EMIT) && (beat_idx == LAST_IDX);
      o_done      = done_reg;
   end

   assign o_cbd_ibytes = byte_buf;
   assign o_cbd_eta    = eta_reg;

endmodule

`default_nettype wire

// File: tb/tb_cbd_ctrl.sv
// tb_cbd_ctrl: scoreboard bench for cbd_ctrl with a behavioural cbd sampler
// attached to the byte buffer / coefficient ports.
`default_nettype none

module tb_cbd_ctrl;

   localparam int IN_W  = 8;
   localparam int OUT_N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    eta = 2'd0;
   logic          busy;
   logic          done;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_data = '0;
   logic [1535:0] cbd_ibytes;
   logic [1:0]    cbd_eta;
   logic [767:0]  cbd_coeffs;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [47:0]   out_data;
   logic          out_last;

   cbd_ctrl #(.IN_W(IN_W), .OUT_N(OUT_N)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_eta        (eta),
      .o_busy       (busy),
      .o_done       (done),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .i_in_data    (in_data),
      .o_cbd_ibytes (cbd_ibytes),
      .o_cbd_eta    (cbd_eta),
      .i_cbd_coeffs (cbd_coeffs),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_data   (out_data),
      .o_out_last   (out_last)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          hs_cnt = 0;
   int          done_cnt = 0;
   int          extra_cnt = 0;
   bit          rand_out = 1'b0;
   logic [7:0]  job_bytes [192];
   logic [47:0] exp_q [$];
   logic        exp_last_q [$];
   logic [47:0] held = '0;
   bit          stalled = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Kyber CBD over the buffer layout: byte j sits at [base-8j -: 8], bits LSB-first
   function automatic logic [767:0] cbd_model(input logic [1535:0] ib, input logic [1:0] e);
      logic [767:0] r;
      int n, base, a, b, p;
      r = '0;
      n = (e == 2'd3) ? 3 : 2;
      base = (n == 3) ? 1535 : 1023;
      for (int i = 0; i < 256; i++) begin
         a = 0;
         b = 0;
         for (int j = 0; j < n; j++) begin
            p = 2*i*n + j;
            a += int'(ib[base - 8*(p/8) - 7 + p%8]);
            p = p + n;
            b += int'(ib[base - 8*(p/8) - 7 + p%8]);
         end
         r[767-3*i -: 3] = 3'(a - b);
      end
      return r;
   endfunction

   assign cbd_coeffs = cbd_model(cbd_ibytes, cbd_eta);

   function automatic logic [11:0] exp_coeff(input int n, input int i);
      int a, b, p;
      a = 0;
      b = 0;
      for (int j = 0; j < n; j++) begin
         p = 2*i*n + j;
         a += int'(job_bytes[p/8][p%8]);
         p = p + n;
         b += int'(job_bytes[p/8][p%8]);
      end
      return (a >= b) ? 12'(a - b) : 12'(3329 + a - b);
   endfunction

   // output / done / input-handshake monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (in_valid && in_ready) hs_cnt++;
      if (done) begin
         done_cnt++;
         check("done_busy", 64'(busy), 64'd0);
      end
      if (out_valid) begin
         if (stalled) check("stall_hold", 64'(out_data), 64'(held));
         if (out_ready) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) extra_cnt++;
            else begin
               check("beat", 64'(out_data), 64'(exp_q.pop_front()));
               check("last", 64'(out_last), 64'(exp_last_q.pop_front()));
            end
         end else begin
            stalled = 1'b1;
            held = out_data;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic fill_pat(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      for (int i = 0; i < 192; i++)
         job_bytes[i] = (i % 3 == 0) ? b0 : ((i % 3 == 1) ? b1 : b2);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 192; i++) job_bytes[i] = 8'($urandom);
   endtask

   task automatic run_job(input int n, input bit gaps, input bit mid_start);
      int nbeats;
      bit got;
      logic [47:0] w;
      nbeats = n * 64 / IN_W;
      for (int beat = 0; beat < 64; beat++) begin
         w = '0;
         for (int k = 0; k < OUT_N; k++) w[(OUT_N-k)*12-1 -: 12] = exp_coeff(n, beat*OUT_N + k);
         exp_q.push_back(w);
         exp_last_q.push_back(beat == 63);
      end
      hs_cnt = 0;
      done_cnt = 0;
      extra_cnt = 0;
      rand_out = gaps;
      @(posedge clk); #1;
      start = 1'b1;
      eta = 2'(n);
      @(posedge clk); #1;
      start = 1'b0;
      eta = 2'd0;
      check("busy_on", 64'(busy), 64'd1);
      for (int b = 0; b < nbeats; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         for (int k = 0; k < IN_W; k++) in_data[63-8*k -: 8] = job_bytes[b*IN_W + k];
         if (mid_start && b == 3) begin
            start = 1'b1;
            eta = (n == 3) ? 2'd2 : 2'd3;
         end
         got = 1'b0;
         for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            eta = 2'd0;
         end
         check("in_ready", 64'(got), 64'd1);
      end
      // keep offering junk to expose over-consumption
      in_data = '1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 3000 && done_cnt == 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      rand_out = 1'b0;
      check("done_cnt", 64'(done_cnt), 64'd1);
      check("in_beats", 64'(hs_cnt), 64'(nbeats));
      check("left", 64'(exp_q.size()), 64'd0);
      check("extra", 64'(extra_cnt), 64'd0);
      check("busy_off", 64'(busy), 64'd0);
      exp_q.delete();
      exp_last_q.delete();
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_last"},  64'(out_last), 64'd0);
      check({tag, "_data"},  64'(out_data), 64'd0);
      check({tag, "_ibuf"},  64'(|cbd_ibytes), 64'd0);
      check({tag, "_eta"},   64'(cbd_eta), 64'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("rst");
      rst = 1'b0;

      // zeros, eta 3
      fill_pat(8'h00, 8'h00, 8'h00);
      run_job(3, 1'b0, 1'b0);
      // 0x03 bytes, eta 2 -> {2,0,2,0}
      fill_pat(8'h03, 8'h03, 8'h03);
      run_job(2, 1'b0, 1'b0);
      // 0x0C bytes, eta 2 -> 3327,0 alternating
      fill_pat(8'h0C, 8'h0C, 8'h0C);
      run_job(2, 1'b0, 1'b0);
      fill_pat(8'h07, 8'h00, 8'h00);
      run_job(3, 1'b0, 1'b0);
      fill_pat(8'h38, 8'h00, 8'h00);
      run_job(3, 1'b0, 1'b0);
      // random data with stalls on both sides
      fill_rand();
      run_job(2, 1'b1, 1'b0);
      fill_rand();
      run_job(3, 1'b1, 1'b0);

      // illegal eta is ignored
      @(posedge clk); #1;
      start = 1'b1;
      eta = 2'd1;
      @(posedge clk); #1;
      start = 1'b0;
      eta = 2'd0;
      @(negedge clk);
      check("eta1_busy", 64'(busy), 64'd0);
      check("eta1_ready", 64'(in_ready), 64'd0);

      // start during LOAD has no effect
      fill_rand();
      run_job(3, 1'b1, 1'b1);

      // reset mid-load aborts cleanly
      @(posedge clk); #1;
      start = 1'b1;
      eta = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      eta = 2'd0;
      in_valid = 1'b1;
      repeat (10) begin
         in_data = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      check("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_idle_zero("abort");
      rst = 1'b0;
      fill_rand();
      run_job(3, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
